// File: rtl/inst_sram_resp.sv
// inst_sram_resp: instruction SRAM model answering a simple SRAM-style port.
//
// Purpose
//   Word-organised memory of 2^DEPTH_LOG2 32-bit words placed at BASE_ADDR.
//   Reads have a fixed one-cycle latency and are read-first with respect to a
//   same-cycle write. Out-of-range accesses return OOR_DATA and never touch the
//   array. A backdoor load port preloads words (usable during reset) and takes
//   priority over a same-cycle SRAM-port write.
//
// Ports
//   clk              clock, rising edge
//   reset            synchronous, active-high
//   inst_sram_en     access request this cycle
//   inst_sram_we     byte write enables (4'h0 = read only)
//   inst_sram_addr   byte address
//   inst_sram_wdata  write data, byte i = bits [8i+7:8i]
//   inst_sram_rdata  registered read data
//   load_en          backdoor preload strobe
//   load_addr        word index for preload
//   load_data        preload word
//   err              sticky access-error flag (out of range or misaligned)
//   rd_cnt           saturating count of accepted accesses
//   wr_cnt           saturating count of accepted accesses with we != 0
module inst_sram_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] OOR_DATA   = 32'h03400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_sram_en,
  input  logic [3:0]            inst_sram_we,
  input  logic [31:0]           inst_sram_addr,
  input  logic [31:0]           inst_sram_wdata,
  output logic [31:0]           inst_sram_rdata,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  err,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  // Byte span of the array; one bit wider than the address so that the
  // comparison cannot wrap for large DEPTH_LOG2.
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset_p0;
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic                  in_range_p0;
  logic                  misaligned_p0;
  logic                  access_p0;
  logic                  port_wr_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffffffff) ? v : v + 32'd1;
  endfunction

  // ---- stage p0: address decode (combinational, same cycle as request) ----
  // Modular subtraction: addresses below BASE_ADDR wrap to large offsets and
  // therefore fall out of range naturally.
  assign offset_p0     = inst_sram_addr - BASE_ADDR;
  assign in_range_p0   = {1'b0, offset_p0} < SPAN;
  assign idx_p0        = offset_p0[DEPTH_LOG2+1:2];
  assign misaligned_p0 = inst_sram_addr[1:0] != 2'b00;
  assign access_p0     = inst_sram_en && !reset;
  // The load port owns the array in a collision cycle; the port write is
  // simply dropped (it is still counted and raises no error).
  assign port_wr_p0    = access_p0 && (inst_sram_we != 4'h0) && in_range_p0 && !load_en;

  // Array storage: never reset, load port honoured even while in reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (port_wr_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_we[i]) begin
          mem[idx_p0][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---- stage p1: registered read data, error flag and counters ----
  // Non-blocking read of mem gives read-first behaviour against the write above.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      err             <= 1'b0;
      rd_cnt          <= 32'h0;
      wr_cnt          <= 32'h0;
    end else if (access_p0) begin
      inst_sram_rdata <= in_range_p0 ? mem[idx_p0] : OOR_DATA;
      if (!in_range_p0 || misaligned_p0) begin
        err <= 1'b1;
      end
      rd_cnt <= sat_inc(rd_cnt);
      if (inst_sram_we != 4'h0) begin
        wr_cnt <= sat_inc(wr_cnt);
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp with a read-data scoreboard.
module tb_inst_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        load_en;
  logic [13:0] load_addr;
  logic [31:0] load_data;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp;

  localparam logic [31:0] OOR = 32'h03400000;

  inst_sram_resp dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .err             (err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SRAM-port cycle; records the expected read data and counter movement.
  task automatic access(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    inst_sram_en    = en;
    inst_sram_we    = we;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    if (en && !reset) begin
      sb.push_back(exp_rdata);
      exp_rd++;
      if (we != 4'h0) exp_wr++;
    end
    step();
    inst_sram_en = 1'b0;
    inst_sram_we = 4'h0;
    load_en      = 1'b0;
  endtask

  task automatic load(input logic [13:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load(14'd0, 32'h02800421);
    load(14'd1, 32'h0280082a);
    access(1'b1, 4'hf, 32'h1c000000, 32'hffffffff, 32'h0);
    n_checks++;
    if (inst_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", inst_sram_rdata, 32'h0); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++;
    if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt); end
    reset = 1'b0;
    step();
    n_checks++;
    if (inst_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want 0", inst_sram_rdata); end
  endtask

  task automatic test_basic_read();
    access(1'b1, 4'h0, 32'h1c000000, 32'h0, 32'h02800421);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL basic_read: got %h want %h", inst_sram_rdata, exp); end
    n_checks++;
    if (rd_cnt !== 32'(exp_rd) || wr_cnt !== 32'(exp_wr)) begin n_fail++; $display("FAIL basic_cnt: got rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 4'h0, 32'h1c000000, 32'h0, 32'h02800421);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL b2b_first: got %h want %h", inst_sram_rdata, exp); end
    access(1'b1, 4'h0, 32'h1c000004, 32'h0, 32'h0280082a);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL b2b_second: got %h want %h", inst_sram_rdata, exp); end
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 4'hf, 32'h1c000000, 32'h0, 32'h0);
      n_checks++;
      if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL b2b_hold%0d: got %h want %h", i, inst_sram_rdata, exp); end
    end
    n_checks++;
    if (rd_cnt !== 32'(exp_rd)) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", rd_cnt, exp_rd); end
  endtask

  task automatic test_byte_write();
    load(14'd2, 32'h11223344);
    n_checks++;
    if (inst_sram_rdata !== 32'h0280082a || rd_cnt !== 32'(exp_rd)) begin n_fail++; $display("FAIL load_side_effect: got %h rd=%0d want %h rd=%0d", inst_sram_rdata, rd_cnt, 32'h0280082a, exp_rd); end
    access(1'b1, 4'b0101, 32'h1c000008, 32'haabbccdd, 32'h11223344);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL write_read_first: got %h want %h", inst_sram_rdata, exp); end
    access(1'b1, 4'h0, 32'h1c000008, 32'h0, 32'h11bb33dd);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL byte_merge: got %h want %h", inst_sram_rdata, exp); end
    n_checks++;
    if (wr_cnt !== 32'(exp_wr) || err !== 1'b0) begin n_fail++; $display("FAIL byte_write_wr_cnt: got wr=%0d err=%b want %0d/0", wr_cnt, err, exp_wr); end
  endtask

  task automatic test_load_collision();
    load(14'd3, 32'hdeadbeef);
    load_en   = 1'b1;
    load_addr = 14'd3;
    load_data = 32'h5;
    access(1'b1, 4'hf, 32'h1c00000c, 32'h9, 32'hdeadbeef);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL collision_read_first: got %h want %h", inst_sram_rdata, exp); end
    access(1'b1, 4'h0, 32'h1c00000c, 32'h0, 32'h5);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL collision_load_wins: got %h want %h", inst_sram_rdata, exp); end
    n_checks++;
    if (wr_cnt !== 32'(exp_wr) || err !== 1'b0) begin n_fail++; $display("FAIL collision_cnt_err: got wr=%0d err=%b want %0d/0", wr_cnt, err, exp_wr); end
  endtask

  task automatic test_out_of_range();
    access(1'b1, 4'h0, 32'h1bfffffc, 32'h0, OOR);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp || err !== 1'b1) begin n_fail++; $display("FAIL oor_below: got %h err=%b want %h err=1", inst_sram_rdata, err, exp); end
    access(1'b1, 4'h0, 32'h1c010000, 32'h0, OOR);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL oor_above: got %h want %h", inst_sram_rdata, exp); end
    // Word 0x4000 aliases word 0 if the range check were missing.
    access(1'b1, 4'hf, 32'h1c010000, 32'hffffffff, OOR);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL oor_write_rdata: got %h want %h", inst_sram_rdata, exp); end
    access(1'b1, 4'h0, 32'h1c000000, 32'h0, 32'h02800421);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp || err !== 1'b1) begin n_fail++; $display("FAIL oor_array_intact: got %h err=%b want %h err=1", inst_sram_rdata, err, exp); end
    n_checks++;
    if (wr_cnt !== 32'(exp_wr)) begin n_fail++; $display("FAIL oor_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
  endtask

  task automatic test_reset_mid();
    n_checks++;
    if (rd_cnt !== 32'(exp_rd)) begin n_fail++; $display("FAIL pre_reset_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (inst_sram_rdata !== 32'h0 || err !== 1'b0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: got rdata=%h err=%b rd=%0d wr=%0d want 0/0/0/0", inst_sram_rdata, err, rd_cnt, wr_cnt);
    end
    reset  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    access(1'b1, 4'h0, 32'h1c000000, 32'h0, 32'h02800421);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp || rd_cnt !== 32'd1 || err !== 1'b0) begin n_fail++; $display("FAIL post_reset_read: got %h rd=%0d err=%b want %h rd=1 err=0", inst_sram_rdata, rd_cnt, err, exp); end
  endtask

  task automatic test_misaligned();
    access(1'b1, 4'h0, 32'h1c000006, 32'h0, 32'h0280082a);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp || err !== 1'b1) begin n_fail++; $display("FAIL misaligned_read: got %h err=%b want %h err=1", inst_sram_rdata, err, exp); end
    access(1'b1, 4'b0010, 32'h1c000005, 32'h0000ee00, 32'h0280082a);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL misaligned_write_rf: got %h want %h", inst_sram_rdata, exp); end
    access(1'b1, 4'h0, 32'h1c000004, 32'h0, 32'h0280ee2a);
    exp = sb.pop_front();
    n_checks++;
    if (inst_sram_rdata !== exp) begin n_fail++; $display("FAIL misaligned_write: got %h want %h", inst_sram_rdata, exp); end
    n_checks++;
    if (rd_cnt !== 32'(exp_rd) || wr_cnt !== 32'(exp_wr)) begin n_fail++; $display("FAIL misaligned_cnt: got rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr); end
  endtask

  initial begin
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_we    = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    load_en         = 1'b0;
    load_addr       = 14'd0;
    load_data       = 32'h0;
    step();
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_byte_write();
    test_load_collision();
    test_out_of_range();
    test_reset_mid();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
